// File: rtl/ps2_keyboard_port_if.sv
// CPU data-memory bus slice seen by the PS/2 keyboard port.
// The CPU drives address, strobes and write data; the port returns read data and its window hit.
interface ps2_keyboard_port_if;
   logic [31:0] m_addr;
   logic        rmem;
   logic        wmem;
   logic [31:0] d_t_mem;
   logic [31:0] rd_data;
   logic        sel;

   modport master (output m_addr, rmem, wmem, d_t_mem, input rd_data, sel);
   modport slave  (input m_addr, rmem, wmem, d_t_mem, output rd_data, sel);
endinterface

// File: rtl/ps2_keyboard_port.sv
// PS/2 keyboard receiver with scan-code FIFO, DATA/STATUS/CTRL registers and level interrupt intr1.
// Optional: define PS2_KBD_TIMEOUT_EN to abandon partial frames after TIMEOUT idle clocks.
module ps2_keyboard_port #(
   parameter logic [31:0] BASE       = 32'hA000_0000,
   parameter int unsigned DEPTH_LOG2 = 3,
   parameter logic [15:0] TIMEOUT    = 16'd50000
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               ps2_clk,
   input  logic               ps2_data,
   ps2_keyboard_port_if.slave bus,
   output logic               intr1
);
   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;
   typedef enum logic [1:0] {REG_DATA, REG_STATUS, REG_CTRL, REG_NONE} reg_off_t;

   // Pin synchronisers; reset to the idle-high bus level so release never looks like an edge.
   logic clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
   logic fall;

   // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_data;
         dat_s2   <= dat_s1;
      end
   end

   assign fall = clk_prev & ~clk_s2;

   rx_state_t   state, state_nxt;
   logic [2:0]  bit_cnt, bit_cnt_nxt;
   logic [7:0]  shift, shift_nxt;
   logic        par_bit, par_nxt;
   logic        push, set_perr, set_ferr;
`ifdef PS2_KBD_TIMEOUT_EN
   logic [15:0] idle_cnt, idle_cnt_nxt;
`endif

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state    <= IDLE;
         bit_cnt  <= '0;
         shift    <= '0;
         par_bit  <= 1'b0;
`ifdef PS2_KBD_TIMEOUT_EN
         idle_cnt <= '0;
`endif
      end else begin
         state    <= state_nxt;
         bit_cnt  <= bit_cnt_nxt;
         shift    <= shift_nxt;
         par_bit  <= par_nxt;
`ifdef PS2_KBD_TIMEOUT_EN
         idle_cnt <= idle_cnt_nxt;
`endif
      end
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shift_nxt   = shift;
      par_nxt     = par_bit;
      push        = 1'b0;
      set_perr    = 1'b0;
      set_ferr    = 1'b0;
      if (fall) begin
         case (state)
            IDLE: if (!dat_s2) begin
               state_nxt   = DATA;
               bit_cnt_nxt = '0;
            end
            DATA: begin
               shift_nxt   = {dat_s2, shift[7:1]};
               bit_cnt_nxt = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nxt = PARITY;
            end
            PARITY: begin
               par_nxt   = dat_s2;
               state_nxt = STOP;
            end
            STOP: begin
               state_nxt = IDLE;
               if (!dat_s2)                set_ferr = 1'b1;
               else if (^{shift, par_bit}) push     = 1'b1;
               else                        set_perr = 1'b1;
            end
            default: state_nxt = IDLE;
         endcase
      end
`ifdef PS2_KBD_TIMEOUT_EN
      idle_cnt_nxt = '0;
      if (state != IDLE && !fall) begin
         if (idle_cnt == TIMEOUT) begin
            state_nxt = IDLE;
            set_ferr  = 1'b1;
         end else begin
            idle_cnt_nxt = idle_cnt + 16'd1;
         end
      end
`endif
   end

   // FIFO and register decode.
   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [DEPTH_LOG2:0]   count;
   logic                  nonempty, full, pop, push_ok;
   logic                  perr, ferr, ovf, ie;
   logic                  ctrl_wr, clr;
   reg_off_t              off;

   assign off      = reg_off_t'(bus.m_addr[3:2]);
   assign bus.sel  = (bus.m_addr[31:4] == BASE[31:4]);
   assign nonempty = (count != '0);
   assign full     = (count == FULL_COUNT);
   assign pop      = bus.sel & bus.rmem & (off == REG_DATA) & nonempty;
   assign push_ok  = push & (~full | pop);
   assign ctrl_wr  = bus.sel & bus.wmem & (off == REG_CTRL);
   assign clr      = ctrl_wr & bus.d_t_mem[1];

   // NOTE: the byte store has no reset; stale entries are unreachable because count gates every read.
   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= shift;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         perr   <= 1'b0;
         ferr   <= 1'b0;
         ovf    <= 1'b0;
         ie     <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)      count <= count + 1'b1;
         else if (!push_ok && pop) count <= count - 1'b1;
         // Set terms are OR-ed last so a flag raised during a clear survives it.
         perr <= (perr & ~clr) | set_perr;
         ferr <= (ferr & ~clr) | set_ferr;
         ovf  <= (ovf  & ~clr) | (push & ~push_ok);
         if (ctrl_wr) ie <= bus.d_t_mem[0];
      end
   end

   assign intr1 = ie & nonempty;

   always_comb begin
      bus.rd_data = '0;
      if (bus.sel) begin
         case (off)
            REG_DATA:   if (nonempty) bus.rd_data = {24'h0, mem[rd_ptr]};
            REG_STATUS: bus.rd_data = {16'h0, 8'(count), 4'h0, ovf, ferr, perr, nonempty};
            REG_CTRL:   bus.rd_data = {31'h0, ie};
            default:    bus.rd_data = '0;
         endcase
      end
   end

   logic unused_bits;
`ifdef PS2_KBD_TIMEOUT_EN
   assign unused_bits = ^{bus.d_t_mem[31:2], bus.m_addr[1:0]};
`else
   assign unused_bits = ^{bus.d_t_mem[31:2], bus.m_addr[1:0], TIMEOUT};
`endif
endmodule

// File: tb/tb_ps2_keyboard_port.sv
// Randomised bench for ps2_keyboard_port against a byte-queue model of the keyboard port.
`timescale 1ns/1ps
module tb_ps2_keyboard_port;
   localparam logic [31:0] BASE    = 32'hA000_0000;
   localparam logic [15:0] TIMEOUT = 16'd300;
   localparam int          DEPTH   = 8;
   localparam int          HALF    = 4;

   logic clock = 1'b0, resetn = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
   logic intr1;
   ps2_keyboard_port_if bus();

   ps2_keyboard_port #(.BASE(BASE), .DEPTH_LOG2(3), .TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .bus(bus), .intr1(intr1)
   );

   always #5 clock = ~clock;

   int total = 0, bad = 0;
   logic [7:0] q[$];
   bit m_perr, m_ferr, m_ovf, m_ie;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Reference model
   function automatic logic [31:0] model_status();
      logic [7:0] c;
      c = 8'(q.size());
      return {16'h0, c, 4'h0, m_ovf, m_ferr, m_perr, q.size() != 0};
   endfunction

   task automatic model_reset();
      q.delete();
      m_perr = 0; m_ferr = 0; m_ovf = 0; m_ie = 1;
   endtask

   task automatic model_ctrl(input logic [31:0] v);
      m_ie = v[0];
      if (v[1]) begin m_perr = 0; m_ferr = 0; m_ovf = 0; end
   endtask

   task automatic model_pop(output logic [31:0] e);
      e = 0;
      if (q.size() != 0) e = 32'(q.pop_front());
   endtask

   task automatic model_frame(input logic [7:0] d, input bit par_ok, input bit stop);
      if (!stop)                m_ferr = 1;
      else if (!par_ok)         m_perr = 1;
      else if (q.size() < DEPTH) q.push_back(d);
      else                      m_ovf = 1;
   endtask

   function automatic logic [10:0] frame_bits(input logic [7:0] d, input bit par_ok, input bit stop);
      logic p;
      p = ~(^d);
      if (!par_ok) p = ~p;
      return {stop, p, d, 1'b0};
   endfunction

   // Bus transactions
   task automatic read_reg(input int off, output logic [31:0] v);
      @(posedge clock); #1 bus.m_addr = BASE + 32'(off * 4);
      @(negedge clock); v = bus.rd_data;
   endtask

   task automatic pop_data(output logic [31:0] v);
      @(posedge clock); #1 bus.m_addr = BASE; bus.rmem = 1'b1;
      @(negedge clock); v = bus.rd_data;
      @(posedge clock); #1 bus.rmem = 1'b0; bus.m_addr = BASE + 32'h4;
   endtask

   task automatic write_reg(input int off, input logic [31:0] v);
      @(posedge clock); #1 bus.m_addr = BASE + 32'(off * 4); bus.d_t_mem = v; bus.wmem = 1'b1;
      @(posedge clock); #1 bus.wmem = 1'b0; bus.m_addr = BASE + 32'h4;
   endtask

   task automatic check_state(input string tag);
      logic [31:0] v;
      read_reg(1, v);
      check({tag, ".status"}, v, model_status());
      check({tag, ".intr1"}, 32'(intr1), 32'(m_ie && q.size() != 0));
   endtask

   task automatic pop_check(input string tag);
      logic [31:0] v, e;
      pop_data(v);
      model_pop(e);
      check(tag, v, e);
   endtask

   // One PS/2 bit; optionally issues a DATA read in the cycle the falling edge is acted on.
   task automatic ps2_bit(input logic b, input bit pop, output logic [31:0] popped);
      popped = '0;
      @(posedge clock); #1 ps2_data = b;
      repeat (HALF) @(posedge clock);
      #1 ps2_clk = 1'b0;
      if (pop) begin
         repeat (2) @(posedge clock);
         #1 bus.m_addr = BASE; bus.rmem = 1'b1;
         @(negedge clock); popped = bus.rd_data;
         @(posedge clock); #1 bus.rmem = 1'b0; bus.m_addr = BASE + 32'h4;
      end
      repeat (HALF) @(posedge clock);
      #1 ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop, input bit pop_at_stop);
      logic [10:0] fb;
      logic [31:0] pv, e;
      fb = frame_bits(d, par_ok, stop);
      for (int i = 0; i < 11; i++) ps2_bit(fb[i], pop_at_stop && i == 10, pv);
      repeat (2) @(posedge clock);
      if (pop_at_stop) begin
         model_pop(e);
         check("stop_pop.data", pv, e);
      end
      model_frame(d, par_ok, stop);
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v, pv;
      logic [10:0] fb;
      bus.m_addr = BASE + 32'h4; bus.rmem = 0; bus.wmem = 0; bus.d_t_mem = 0;
      model_reset();
      repeat (3) @(posedge clock);
      @(negedge clock) resetn = 1'b1;

      // Reset state
      check_state("reset");
      read_reg(2, v); check("reset.ctrl", v, 32'h1);
      read_reg(3, v); check("reset.reg3", v, 32'h0);
      check("reset.sel", 32'(bus.sel), 32'h1);

      // Single good frame
      send_frame(8'h1C, 1, 1, 0);
      read_reg(1, v); check("t1.status_lit", v, 32'h0000_0101);
      check_state("t1");
      pop_check("t1.data");
      check_state("t1.empty");

      // Bad parity, then clear
      send_frame(8'h5A, 0, 1, 0);
      check_state("t2.perr");
      write_reg(2, 32'h3); model_ctrl(32'h3);
      check_state("t2.clr");

      // Overflow at depth 8
      for (int d = 1; d <= 9; d++) send_frame(8'(d), 1, 1, 0);
      read_reg(1, v); check("t3.status_lit", v, 32'h0000_0809);
      @(posedge clock); #1 bus.m_addr = BASE + 32'h10;
      @(negedge clock);
      check("t3.sel_out", 32'(bus.sel), 32'h0);
      check("t3.rd_out", bus.rd_data, 32'h0);
      write_reg(3, 32'h0);
      check_state("t3.reg3_wr");
      for (int i = 0; i < 8; i++) pop_check("t3.data");
      write_reg(2, 32'h3); model_ctrl(32'h3);
      check_state("t3.clr");

      // Interrupt enable gating
      send_frame(8'h11, 1, 1, 0);
      send_frame(8'h22, 1, 1, 0);
      write_reg(2, 32'h0); model_ctrl(32'h0);
      check_state("t4.ie0");
      write_reg(2, 32'h1); model_ctrl(32'h1);
      check_state("t4.ie1");
      for (int i = 0; i < 3; i++) pop_check("t4.data");
      check_state("t4.empty");

      // Push and pop in the same cycle with a full FIFO
      for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1, 1, 0);
      send_frame(8'hA5, 1, 1, 1);
      read_reg(1, v); check("t5.status_lit", v, 32'h0000_0801);
      for (int i = 0; i < DEPTH; i++) pop_check("t5.data");
      check_state("t5.empty");

      // Partial frame: start + 3 bits, then a long idle gap
      fb = frame_bits(8'h29, 1, 1);
      for (int i = 0; i < 4; i++) ps2_bit(fb[i], 0, pv);
      repeat (int'(TIMEOUT) + 5) @(posedge clock);
`ifdef PS2_KBD_TIMEOUT_EN
      m_ferr = 1;
      check_state("t6.timeout");
      write_reg(2, 32'h3); model_ctrl(32'h3);
      send_frame(8'h29, 1, 1, 0);
`else
      check_state("t6.waiting");
      for (int i = 4; i < 11; i++) ps2_bit(fb[i], 0, pv);
      repeat (2) @(posedge clock);
      model_frame(8'h29, 1, 1);
`endif
      read_reg(0, v); check("t6.head_lit", v, 32'h0000_0029);
      pop_check("t6.data");
      check_state("t6.after");

      // Asynchronous reset mid-frame with bytes queued
      for (int i = 0; i < 3; i++) send_frame(8'(8'h40 + i), 1, 1, 0);
      send_frame(8'h77, 0, 1, 0);
      fb = frame_bits(8'h33, 1, 1);
      for (int i = 0; i < 5; i++) ps2_bit(fb[i], 0, pv);
      bus.m_addr = BASE + 32'h4;
      @(posedge clock); #2 ps2_clk = 1'b0;
      #1 resetn = 1'b0;
      #1;
      model_reset();
      check("t7.async_status", bus.rd_data, 32'h0);
      check("t7.async_intr1", 32'(intr1), 32'h0);
      ps2_clk = 1'b1; ps2_data = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock) resetn = 1'b1;
      repeat (4) @(posedge clock);
      check_state("t7.after");
      read_reg(2, v); check("t7.ctrl", v, 32'h1);

      // Randomised traffic
      for (int n = 0; n < 80; n++) begin
         int r, k;
         r = $urandom_range(0, 9);
         if (r < 5) begin
            k = $urandom_range(0, 7);
            send_frame(8'($urandom), k != 0, k != 1, (k == 2) && (q.size() != 0));
         end else if (r < 8) begin
            pop_check("rnd.data");
         end else if (r == 8) begin
            v = 32'($urandom_range(0, 3));
            write_reg(2, v); model_ctrl(v);
         end else begin
            write_reg(3, $urandom);
         end
         check_state("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
